// File: rtl/memory_param.sv
//------------------------------------------------------------------------------
// memory_param: DEPTH x DATA_W synchronous RAM with a power-up zeroing sweep,
// registered reads and rejected-write reporting.
// Build option MEM_BYPASS_EN: same-address read-during-write returns data_in.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module memory_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_add,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_add,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rvalid_q, rvalid_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;

`ifdef MEM_BYPASS_EN
    assign rd_data = (we && (w_add == r_add)) ? data_in : mem_q[r_add];
`else
    assign rd_data = mem_q[r_add];
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        data_out_d = data_out_q;
        rvalid_d   = 1'b0;
        wr_drop_d  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = w_add;
        wr_data    = data_in;

        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_addr    = init_cnt_q;
                wr_data    = '0;
                // Counter wraps to zero naturally as the last word is cleared.
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                wr_drop_d  = we;
                if (&init_cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = we;
                if (re) begin
                    data_out_d = rd_data;
                    rvalid_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            data_out_q <= '0;
            rvalid_q   <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            data_out_q <= data_out_d;
            rvalid_q   <= rvalid_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Storage carries no reset; the sweep provides the zero contents.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign data_out = data_out_q;
    assign rvalid   = rvalid_q;
    assign wr_drop  = wr_drop_q;
    assign busy     = !rst || (state_q == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_memory_param.sv
//------------------------------------------------------------------------------
// tb_memory_param: directed scoreboard bench for memory_param (8x16).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] w_add;
    logic [DATA_W-1:0] data_in;
    logic              re;
    logic [ADDR_W-1:0] r_add;
    logic [DATA_W-1:0] data_out;
    logic              rvalid;
    logic              busy;
    logic              wr_drop;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    memory_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .we(we), .w_add(w_add), .data_in(data_in),
        .re(re), .r_add(r_add), .data_out(data_out), .rvalid(rvalid),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; w_add = '0; r_add = '0; data_in = '0;
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1; w_add = ADDR_W'(a); data_in = DATA_W'(d);
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input int a, input int exp);
        re = 1'b1; r_add = ADDR_W'(a);
        exp_q.push_back(DATA_W'(exp));
        tick();
        re = 1'b0;
    endtask

    // Walk the sweep: busy must stay high for exactly 16 edges after release.
    task automatic sweep(input bit drop_test);
        for (int k = 1; k <= 16; k++) begin
            we = drop_test && (k == 10);
            w_add = 4'd2; data_in = 8'h77;
            re = drop_test && (k == 12);
            r_add = 4'd5;
            tick();
            check($sformatf("busy_edge%0d", k), int'(busy), (k < 16) ? 1 : 0);
            if (drop_test && k == 10) check("wr_drop_pulse", int'(wr_drop), 1);
            if (drop_test && k == 11) check("wr_drop_clear", int'(wr_drop), 0);
        end
        idle();
    endtask

    // Monitor: every rvalid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 1, 0);
            end else begin
                check("read_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 1);
        check("rst_data_out", int'(data_out), 0);
        check("rst_rvalid", int'(rvalid), 0);
        check("rst_wr_drop", int'(wr_drop), 0);

        rst = 1'b1;
        sweep(1'b1);
        rd(5, 8'h00);

        wr(0, 10);
        wr(1, 8);
        wr(4, 5);
        rd(0, 10);
        rd(1, 8);
        rd(4, 5);
        rd(2, 8'h00);

        wr(3, 8'hAA);
        we = 1'b1; w_add = 4'd3; data_in = 8'h55;
`ifdef MEM_BYPASS_EN
        rd(3, 8'h55);
`else
        rd(3, 8'hAA);
`endif
        idle();
        rd(3, 8'h55);

        // Adjacent-address independence, including the top word.
        wr(15, 8'h33);
        rd(15, 8'h33);
        rd(14, 8'h00);

        // Mid-run reset with a write attempted while reset is held.
        rst = 1'b0;
        we = 1'b1; w_add = 4'd15; data_in = 8'hEE;
        tick();
        check("midrst_busy", int'(busy), 1);
        check("midrst_data_out", int'(data_out), 0);
        idle();
        rst = 1'b1;
        sweep(1'b0);
        rd(15, 8'h00);
        rd(3, 8'h00);

        wr(15, 8'h33);
        rd(15, 8'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_data_%0d", i), int'(data_out), 8'h33);
            check($sformatf("hold_rvalid_%0d", i), int'(rvalid), 0);
        end

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
